// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement sequencer.
// Holds the sequencer state encoding, the default geometry of the delay line
// and coarse counter, and the fill bit used to build the timeout record.
package tdc_pkg;

  localparam int DEF_NUM_TAPS       = 195;
  localparam int DEF_COARSE_WIDTH   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  // A timeout record is the full out_time word filled with this bit.
  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Coarse cycle counter for the TDC sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (has priority over en_i)
//   en_i       : count up by one
//   count_o    : current coarse count
//   tc_o       : terminal count, high while count_o == TIMEOUT_CYCLES-1
module tdc_coarse_counter
  import tdc_pkg::*;
#(
  parameter int COARSE_WIDTH   = DEF_COARSE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  output logic [COARSE_WIDTH-1:0] count_o,
  output logic                    tc_o
);

  localparam logic [COARSE_WIDTH-1:0] TC_VALUE = COARSE_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COARSE_WIDTH-1:0] count_q;

  // Counter register: clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {COARSE_WIDTH{1'b0}};
    end else if (clr_i) begin
      count_q <= {COARSE_WIDTH{1'b0}};
    end else if (en_i) begin
      count_q <= count_q + {{(COARSE_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TC_VALUE);

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the tapped-delay-line TDC.
// Arms the delay line on start, runs the coarse counter while armed, and
// captures {coarse, fine} on the stop hit (or a timeout record) for a
// valid/ready output. All outputs are registered.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : arm request, honoured only in IDLE
//   hit_valid         : one-cycle stop-hit pulse
//   fine_index        : fine tap index qualified by hit_valid
//   dl_enable         : delay-line sampling enable (ARMED only)
//   busy              : high outside IDLE
//   out_valid         : record available
//   out_ready         : downstream accept
//   out_time          : {coarse, fine} or all ones on timeout
//   out_timeout       : record is a timeout
//   drop_count        : saturating count of hits seen outside ARMED
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int NUM_TAPS       = DEF_NUM_TAPS,
  parameter int FINE_WIDTH     = $clog2(NUM_TAPS),
  parameter int COARSE_WIDTH   = DEF_COARSE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               hit_valid,
  input  logic [FINE_WIDTH-1:0]              fine_index,
  output logic                               dl_enable,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [COARSE_WIDTH+FINE_WIDTH-1:0] out_time,
  output logic                               out_timeout,
  output logic [7:0]                         drop_count
);

  localparam int TW = COARSE_WIDTH + FINE_WIDTH;
  localparam logic [FINE_WIDTH-1:0] FINE_MAX = FINE_WIDTH'(NUM_TAPS - 1);

  state_e state_q, state_d;

  logic [COARSE_WIDTH-1:0] coarse_s;
  logic                    tc_s;
  logic                    cnt_clr_s;
  logic                    cnt_en_s;
  logic [FINE_WIDTH-1:0]   fine_clamp_s;

  logic          dl_enable_q, dl_enable_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic [TW-1:0] out_time_q, out_time_d;
  logic          out_timeout_q, out_timeout_d;
  logic [7:0]    drop_count_q, drop_count_d;

  // Coarse runs from zero at arm time and only advances on hit-free ARMED cycles.
  assign cnt_clr_s = (state_q == ST_IDLE);
  assign cnt_en_s  = (state_q == ST_ARMED) && !hit_valid;

  tdc_coarse_counter #(
    .COARSE_WIDTH   (COARSE_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_coarse (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr_s),
    .en_i    (cnt_en_s),
    .count_o (coarse_s),
    .tc_o    (tc_s)
  );

  // Encoder codes beyond the last tap are pinned to the last tap.
  assign fine_clamp_s = (fine_index > FINE_MAX) ? FINE_MAX : fine_index;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a hit on the terminal-count cycle still leaves as a hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARMED;
        else       state_d = ST_IDLE;
      end
      ST_ARMED: begin
        if (hit_valid || tc_s) state_d = ST_OUTPUT;
        else                   state_d = ST_ARMED;
      end
      ST_OUTPUT: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
        else                          state_d = ST_OUTPUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: flags follow the next state so they are registered
  // yet aligned with it; the record is captured only on leaving ARMED.
  always_comb begin
    dl_enable_d   = (state_d == ST_ARMED);
    busy_d        = (state_d != ST_IDLE);
    out_valid_d   = (state_d == ST_OUTPUT);
    out_time_d    = out_time_q;
    out_timeout_d = out_timeout_q;
    drop_count_d  = drop_count_q;
    if (state_q == ST_ARMED && hit_valid) begin
      out_time_d    = {coarse_s, fine_clamp_s};
      out_timeout_d = 1'b0;
    end else if (state_q == ST_ARMED && tc_s) begin
      out_time_d    = {TW{TIMEOUT_FILL_BIT}};
      out_timeout_d = 1'b1;
    end else begin
      out_time_d    = out_time_q;
      out_timeout_d = out_timeout_q;
    end
    if (hit_valid && (state_q != ST_ARMED) && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_time_q    <= {TW{1'b0}};
      out_timeout_q <= 1'b0;
      drop_count_q  <= 8'd0;
    end else begin
      dl_enable_q   <= dl_enable_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_time_q    <= out_time_d;
      out_timeout_q <= out_timeout_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign dl_enable   = dl_enable_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_time    = out_time_q;
  assign out_timeout = out_timeout_q;
  assign drop_count  = drop_count_q;

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the tapped-delay-line TDC. Arms the delay line on a start command, runs the coarse cycle counter, and captures the coarse count together with the fine tap index from the one-hot-to-binary encoder when the stop hit arrives. Presents one timestamp per measurement on a valid/ready output, or a timeout record if no hit arrives.

## Interface
- `NUM_TAPS`, 195: delay-line taps; legal fine index range is 0..NUM_TAPS-1.
- `FINE_WIDTH`, `$clog2(NUM_TAPS)`: fine index width.
- `COARSE_WIDTH`, 16: coarse counter width.
- `TIMEOUT_CYCLES`, 1000: ARMED cycles before timeout; must be in 1..2^COARSE_WIDTH-1.

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  arm request; sampled only in IDLE.
- `hit_valid`  in  1  one-cycle stop-hit pulse from the encoder stage.
- `fine_index`  in  FINE_WIDTH  encoder output; qualified by `hit_valid`.
- `dl_enable`  out  1  delay-line sampling enable; high only in ARMED.
- `busy`  out  1  high in every state except IDLE.
- `out_valid`  out  1  timestamp available.
- `out_ready`  in  1  downstream accept.
- `out_time`  out  COARSE_WIDTH+FINE_WIDTH  {coarse, fine}.
- `out_timeout`  out  1  record is a timeout, not a hit.
- `drop_count`  out  8  saturating count of hits ignored outside ARMED.

## Operation
- States: IDLE, ARMED, OUTPUT.
- IDLE: `start`=1 -> ARMED; coarse <= 0.
- ARMED: `dl_enable`=1. Each cycle without hit: coarse increments.
  - `hit_valid`=1 -> OUTPUT; latch {coarse, clamped fine}, `out_timeout`=0.
  - No hit and coarse == TIMEOUT_CYCLES-1 -> OUTPUT; `out_time` = all ones, `out_timeout`=1.
  - Hit and timeout in the same cycle: hit wins.
- OUTPUT: `out_valid`=1; `out_time` and `out_timeout` held stable until `out_valid && out_ready`, then -> IDLE.
- Fine clamp: `fine_index` > NUM_TAPS-1 is latched as NUM_TAPS-1.
- `start` outside IDLE is ignored. `start` and `hit_valid` together in IDLE: arm only; the hit is counted as a drop.
- `hit_valid` in IDLE or OUTPUT: `drop_count` increments, saturating at 255. Cleared only by reset.
- Reset (any time, including mid-measurement): state IDLE; coarse 0; all outputs 0 (`out_time`=0, `drop_count`=0). Any pending record is discarded.

## Timing
- `start` at cycle T -> ARMED, `dl_enable`=1, `busy`=1 at T+1.
- Hit sampled at ARMED cycle T+1+N (coarse = N) -> `out_valid`=1 with `out_time`={N, fine} at T+2+N.
- Timeout: with no hit, `out_valid` rises exactly TIMEOUT_CYCLES+1 cycles after the `start` cycle.
- Handshake at cycle H -> IDLE and `busy`=0 at H+1. The earliest next `start` is accepted at H+1.
- `out_ready` held high: OUTPUT lasts exactly one cycle.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `tdc_pkg` holds:
  - state enum (IDLE/ARMED/OUTPUT);
  - default NUM_TAPS/COARSE_WIDTH constants;
  - timeout record value (all ones).
- Sub-module `tdc_coarse_counter`: clear/enable counter with terminal-count flag at TIMEOUT_CYCLES-1.
- The one-hot encoder is instantiated outside this block, upstream of `fine_index`.

## Test plan
- Reset, `start`, hit at coarse=5 with `fine_index`=37, `out_ready`=1 -> one-cycle `out_valid`, `out_time`={16'd5, 8'd37}, `out_timeout`=0, `busy` falls the next cycle.
- TIMEOUT_CYCLES=10, `start`, no hit -> `out_valid` 11 cycles after `start`, `out_time`=all ones, `out_timeout`=1.
- Hit and terminal count in the same cycle (coarse=9, fine=3) -> `out_time`={9, 3}, `out_timeout`=0.
- `fine_index`=250 with NUM_TAPS=195 -> latched fine=194.
- `out_ready` low for 20 cycles while 3 hits and 2 `start` pulses arrive -> record stable throughout, `drop_count`=3, `start` ignored, IDLE only after handshake.
- Reset asserted mid-ARMED -> outputs 0 immediately; a new `start` after release measures from coarse=0.
